// File: rtl/alu_rs_pkg.sv
// Shared types and helpers for the ALU reservation station / issue scheduler.
// Entry field widths follow the package defaults below.
package alu_rs_pkg;

    localparam int RS_DEPTH  = 8;
    localparam int RS_TAG_W  = 4;
    localparam int RS_DATA_W = 32;
    localparam int RS_OP_W   = 5;

    // Tag MSB set means the operand value is already present.
    localparam logic [RS_TAG_W-1:0] TAG_FREE = {1'b1, {(RS_TAG_W-1){1'b0}}};

    typedef struct packed {
        logic                 valid;
        logic [RS_OP_W-1:0]   op;
        logic [RS_TAG_W-2:0]  dest;
        logic [RS_TAG_W-1:0]  tag1;
        logic [RS_DATA_W-1:0] data1;
        logic [RS_TAG_W-1:0]  tag2;
        logic [RS_DATA_W-1:0] data2;
    } rs_entry_t;

    function automatic logic tag_is_free(input logic [RS_TAG_W-1:0] tag);
        return tag[RS_TAG_W-1];
    endfunction

endpackage

// File: rtl/alu_issue_scheduler_if.sv
// Decoder allocation, CDB snoop and ALU issue signals of the issue scheduler.
// The scheduler uses the slave modport; the decoder/ALU side uses master.
interface alu_issue_scheduler_if #(
    parameter int TAG_W  = alu_rs_pkg::RS_TAG_W,
    parameter int DATA_W = alu_rs_pkg::RS_DATA_W,
    parameter int OP_W   = alu_rs_pkg::RS_OP_W
) ();

    logic              alloc_valid;
    logic              alloc_ready;
    logic [OP_W-1:0]   alloc_op;
    logic [TAG_W-2:0]  alloc_dest;
    logic [TAG_W-1:0]  alloc_tag1;
    logic [DATA_W-1:0] alloc_data1;
    logic [TAG_W-1:0]  alloc_tag2;
    logic [DATA_W-1:0] alloc_data2;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-2:0]  issue_dest;
    logic [DATA_W-1:0] issue_data1;
    logic [DATA_W-1:0] issue_data2;

    modport master (
        output alloc_valid, alloc_op, alloc_dest, alloc_tag1, alloc_data1,
               alloc_tag2, alloc_data2,
        output cdb_valid, cdb_tag, cdb_data,
        output issue_ready,
        input  alloc_ready,
        input  issue_valid, issue_op, issue_dest, issue_data1, issue_data2
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_dest, alloc_tag1, alloc_data1,
               alloc_tag2, alloc_data2,
        input  cdb_valid, cdb_tag, cdb_data,
        input  issue_ready,
        output alloc_ready,
        output issue_valid, issue_op, issue_dest, issue_data1, issue_data2
    );

endinterface

// File: rtl/rs_priority_pick.sv
// Lowest-index one-hot picker: grants the least significant set request bit.
module rs_priority_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/alu_issue_scheduler.sv
// Reservation station between decoder and integer ALU: buffers ops, snoops the
// CDB for pending operands and issues ready ops through a registered output stage.
module alu_issue_scheduler
    import alu_rs_pkg::*;
#(
    parameter int DEPTH  = RS_DEPTH,
    parameter int TAG_W  = RS_TAG_W,
    parameter int DATA_W = RS_DATA_W,
    parameter int OP_W   = RS_OP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    alu_issue_scheduler_if.slave     rs,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    rs_entry_t entries_q [DEPTH];
    rs_entry_t entries_d [DEPTH];

    logic              issue_valid_q, issue_valid_d;
    logic [OP_W-1:0]   issue_op_q,    issue_op_d;
    logic [TAG_W-2:0]  issue_dest_q,  issue_dest_d;
    logic [DATA_W-1:0] issue_data1_q, issue_data1_d;
    logic [DATA_W-1:0] issue_data2_q, issue_data2_d;
    logic [OCC_W-1:0]  occupancy_q,   occupancy_d;

    logic [DEPTH-1:0] free_req, free_oh;
    logic [DEPTH-1:0] elig_req, sel_oh;
    logic             free_any, sel_any;
    logic             alloc_fire, select_fire;
    rs_entry_t        alloc_entry, sel_entry;

    // Eligibility is judged only on registered entry state.
    always_comb begin
        free_req = '0;
        elig_req = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_req[i] = !entries_q[i].valid;
            elig_req[i] = entries_q[i].valid && tag_is_free(entries_q[i].tag1)
                          && tag_is_free(entries_q[i].tag2);
        end
    end

    rs_priority_pick #(.N(DEPTH)) u_free_pick (
        .req (free_req),
        .gnt (free_oh),
        .any (free_any)
    );

    rs_priority_pick #(.N(DEPTH)) u_issue_pick (
        .req (elig_req),
        .gnt (sel_oh),
        .any (sel_any)
    );

    assign rs.alloc_ready = (occupancy_q != OCC_W'(DEPTH));
    assign alloc_fire     = rs.alloc_valid && rs.alloc_ready && free_any;
    assign select_fire    = sel_any && (!issue_valid_q || rs.issue_ready);

    // An operand broadcast on the CDB in the allocation cycle is captured directly.
    always_comb begin
        alloc_entry       = '0;
        alloc_entry.valid = 1'b1;
        alloc_entry.op    = rs.alloc_op;
        alloc_entry.dest  = rs.alloc_dest;
        alloc_entry.tag1  = rs.alloc_tag1;
        alloc_entry.data1 = rs.alloc_data1;
        alloc_entry.tag2  = rs.alloc_tag2;
        alloc_entry.data2 = rs.alloc_data2;
        if (rs.cdb_valid && rs.alloc_tag1 == rs.cdb_tag) begin
            alloc_entry.tag1  = TAG_FREE;
            alloc_entry.data1 = rs.cdb_data;
        end
        if (rs.cdb_valid && rs.alloc_tag2 == rs.cdb_tag) begin
            alloc_entry.tag2  = TAG_FREE;
            alloc_entry.data2 = rs.cdb_data;
        end
    end

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_entry = sel_entry | entries_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (rs.cdb_valid && entries_q[i].valid) begin
                if (entries_q[i].tag1 == rs.cdb_tag) begin
                    entries_d[i].tag1  = TAG_FREE;
                    entries_d[i].data1 = rs.cdb_data;
                end
                if (entries_q[i].tag2 == rs.cdb_tag) begin
                    entries_d[i].tag2  = TAG_FREE;
                    entries_d[i].data2 = rs.cdb_data;
                end
            end
            if (select_fire && sel_oh[i]) begin
                entries_d[i].valid = 1'b0;
            end
            if (alloc_fire && free_oh[i]) begin
                entries_d[i] = alloc_entry;
            end
            if (flush) begin
                entries_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_op_d    = issue_op_q;
        issue_dest_d  = issue_dest_q;
        issue_data1_d = issue_data1_q;
        issue_data2_d = issue_data2_q;
        if (flush) begin
            issue_valid_d = 1'b0;
        end else if (select_fire) begin
            issue_valid_d = 1'b1;
            issue_op_d    = sel_entry.op;
            issue_dest_d  = sel_entry.dest;
            issue_data1_d = sel_entry.data1;
            issue_data2_d = sel_entry.data2;
        end else if (rs.issue_ready) begin
            issue_valid_d = 1'b0;
        end
    end

    always_comb begin
        if (flush) begin
            occupancy_d = '0;
        end else begin
            occupancy_d = occupancy_q + OCC_W'(alloc_fire) - OCC_W'(select_fire);
        end
    end

    // Entry payloads need no reset; only the valid bits are cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_dest_q  <= '0;
            issue_data1_q <= '0;
            issue_data2_q <= '0;
            occupancy_q   <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_dest_q  <= issue_dest_d;
            issue_data1_q <= issue_data1_d;
            issue_data2_q <= issue_data2_d;
            occupancy_q   <= occupancy_d;
        end
    end

    assign rs.issue_valid = issue_valid_q;
    assign rs.issue_op    = issue_op_q;
    assign rs.issue_dest  = issue_dest_q;
    assign rs.issue_data1 = issue_data1_q;
    assign rs.issue_data2 = issue_data2_q;
    assign occupancy      = occupancy_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed self-checking bench for alu_issue_scheduler (DEPTH 8, TAG_W 4, DATA_W 32, OP_W 5).
module tb_alu_issue_scheduler;

    localparam logic [3:0] FREE = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] occupancy;
    int         tests_run = 0;
    int         tests_failed = 0;

    alu_issue_scheduler_if bus ();

    alu_issue_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .rs        (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // {issue_valid, op, dest, data1, data2}
    function automatic logic [72:0] issue_vec();
        return {bus.issue_valid, bus.issue_op, bus.issue_dest, bus.issue_data1, bus.issue_data2};
    endfunction

    // {alloc_ready, occupancy}
    function automatic logic [4:0] stat_vec();
        return {bus.alloc_ready, occupancy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush           = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_op    = '0;
        bus.alloc_dest  = '0;
        bus.alloc_tag1  = FREE;
        bus.alloc_data1 = '0;
        bus.alloc_tag2  = FREE;
        bus.alloc_data2 = '0;
        bus.cdb_valid   = 1'b0;
        bus.cdb_tag     = '0;
        bus.cdb_data    = '0;
        bus.issue_ready = 1'b1;
    endtask

    task automatic set_alloc(input logic [4:0] op, input logic [2:0] dest,
                             input logic [3:0] t1, input logic [31:0] d1,
                             input logic [3:0] t2, input logic [31:0] d2);
        bus.alloc_valid = 1'b1;
        bus.alloc_op    = op;
        bus.alloc_dest  = dest;
        bus.alloc_tag1  = t1;
        bus.alloc_data1 = d1;
        bus.alloc_tag2  = t2;
        bus.alloc_data2 = d2;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (issue_vec() !== 73'd0) begin
            tests_failed++;
            $display("FAIL reset_issue: got %h want 0", issue_vec());
        end
        tests_run++;
        if (stat_vec() !== {1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_stat: got %h want %h", stat_vec(), {1'b1, 4'd0});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_ready_alloc();
        set_alloc(5'd0, 3'd3, FREE, 32'd5, FREE, 32'd7);
        step();
        bus.alloc_valid = 1'b0;
        tests_run++;
        if ({bus.issue_valid, stat_vec()} !== {1'b0, 1'b1, 4'd1}) begin
            tests_failed++;
            $display("FAIL ready_alloc_written: got %h want %h", {bus.issue_valid, stat_vec()}, {1'b0, 1'b1, 4'd1});
        end
        step();
        tests_run++;
        if (issue_vec() !== {1'b1, 5'd0, 3'd3, 32'd5, 32'd7}) begin
            tests_failed++;
            $display("FAIL ready_alloc_issue: got %h want %h", issue_vec(), {1'b1, 5'd0, 3'd3, 32'd5, 32'd7});
        end
        tests_run++;
        if (stat_vec() !== {1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL ready_alloc_occ: got %h want %h", stat_vec(), {1'b1, 4'd0});
        end
        step();
        tests_run++;
        if (bus.issue_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_drop: got %b want 0", bus.issue_valid);
        end
    endtask

    task automatic test_cdb_wakeup();
        set_alloc(5'd1, 3'd4, 4'd2, 32'd0, FREE, 32'd9);
        step();
        bus.alloc_valid = 1'b0;
        step();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'd2;
        bus.cdb_data  = 32'h1234;
        step();
        bus.cdb_valid = 1'b0;
        tests_run++;
        if ({bus.issue_valid, stat_vec()} !== {1'b0, 1'b1, 4'd1}) begin
            tests_failed++;
            $display("FAIL wakeup_not_early: got %h want %h", {bus.issue_valid, stat_vec()}, {1'b0, 1'b1, 4'd1});
        end
        step();
        tests_run++;
        if (issue_vec() !== {1'b1, 5'd1, 3'd4, 32'h1234, 32'd9}) begin
            tests_failed++;
            $display("FAIL wakeup_issue: got %h want %h", issue_vec(), {1'b1, 5'd1, 3'd4, 32'h1234, 32'd9});
        end
        step();
    endtask

    task automatic test_dual_wakeup();
        set_alloc(5'd7, 3'd2, 4'd6, 32'd0, 4'd6, 32'd0);
        step();
        bus.alloc_valid = 1'b0;
        bus.cdb_valid   = 1'b1;
        bus.cdb_tag     = 4'd6;
        bus.cdb_data    = 32'h77;
        step();
        bus.cdb_valid = 1'b0;
        step();
        tests_run++;
        if (issue_vec() !== {1'b1, 5'd7, 3'd2, 32'h77, 32'h77}) begin
            tests_failed++;
            $display("FAIL dual_wakeup: got %h want %h", issue_vec(), {1'b1, 5'd7, 3'd2, 32'h77, 32'h77});
        end
        step();
    endtask

    task automatic test_alloc_bypass();
        set_alloc(5'd2, 3'd1, 4'd4, 32'd0, FREE, 32'h11);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'd4;
        bus.cdb_data  = 32'hAB;
        step();
        bus.alloc_valid = 1'b0;
        bus.cdb_valid   = 1'b0;
        step();
        tests_run++;
        if (issue_vec() !== {1'b1, 5'd2, 3'd1, 32'hAB, 32'h11}) begin
            tests_failed++;
            $display("FAIL alloc_bypass: got %h want %h", issue_vec(), {1'b1, 5'd2, 3'd1, 32'hAB, 32'h11});
        end
        step();
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            set_alloc(5'd1, 3'(i), 4'(i), 32'd0, FREE, 32'(100 + i));
            step();
        end
        tests_run++;
        if (stat_vec() !== {1'b0, 4'd8}) begin
            tests_failed++;
            $display("FAIL full_stat: got %h want %h", stat_vec(), {1'b0, 4'd8});
        end
        set_alloc(5'd9, 3'd6, FREE, 32'h99, FREE, 32'h9A);
        step();
        step();
        tests_run++;
        if ({bus.issue_valid, stat_vec()} !== {1'b0, 1'b0, 4'd8}) begin
            tests_failed++;
            $display("FAIL full_refuse: got %h want %h", {bus.issue_valid, stat_vec()}, {1'b0, 1'b0, 4'd8});
        end
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'd5;
        bus.cdb_data  = 32'h55;
        step();
        bus.cdb_valid = 1'b0;
        tests_run++;
        if ({bus.issue_valid, stat_vec()} !== {1'b0, 1'b0, 4'd8}) begin
            tests_failed++;
            $display("FAIL full_wake_edge: got %h want %h", {bus.issue_valid, stat_vec()}, {1'b0, 1'b0, 4'd8});
        end
        step();
        tests_run++;
        if ({issue_vec(), stat_vec()} !== {1'b1, 5'd1, 3'd5, 32'h55, 32'd105, 1'b1, 4'd7}) begin
            tests_failed++;
            $display("FAIL full_issue5: got %h want %h", {issue_vec(), stat_vec()}, {1'b1, 5'd1, 3'd5, 32'h55, 32'd105, 1'b1, 4'd7});
        end
        step();
        bus.alloc_valid = 1'b0;
        tests_run++;
        if ({bus.issue_valid, stat_vec()} !== {1'b0, 1'b0, 4'd8}) begin
            tests_failed++;
            $display("FAIL full_refill: got %h want %h", {bus.issue_valid, stat_vec()}, {1'b0, 1'b0, 4'd8});
        end
        step();
        tests_run++;
        if ({issue_vec(), stat_vec()} !== {1'b1, 5'd9, 3'd6, 32'h99, 32'h9A, 1'b1, 4'd7}) begin
            tests_failed++;
            $display("FAIL full_held_op: got %h want %h", {issue_vec(), stat_vec()}, {1'b1, 5'd9, 3'd6, 32'h99, 32'h9A, 1'b1, 4'd7});
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++;
        if ({bus.issue_valid, stat_vec()} !== {1'b0, 1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL full_flush: got %h want %h", {bus.issue_valid, stat_vec()}, {1'b0, 1'b1, 4'd0});
        end
    endtask

    task automatic test_back_to_back();
        bus.issue_ready = 1'b0;
        set_alloc(5'd2, 3'd1, FREE, 32'h10, FREE, 32'h20);
        step();
        set_alloc(5'd3, 3'd2, FREE, 32'h30, FREE, 32'h40);
        step();
        bus.alloc_valid = 1'b0;
        tests_run++;
        if ({issue_vec(), stat_vec()} !== {1'b1, 5'd2, 3'd1, 32'h10, 32'h20, 1'b1, 4'd1}) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h want %h", {issue_vec(), stat_vec()}, {1'b1, 5'd2, 3'd1, 32'h10, 32'h20, 1'b1, 4'd1});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (issue_vec() !== {1'b1, 5'd2, 3'd1, 32'h10, 32'h20}) begin
                tests_failed++;
                $display("FAIL b2b_stall%0d: got %h want %h", i, issue_vec(), {1'b1, 5'd2, 3'd1, 32'h10, 32'h20});
            end
        end
        bus.issue_ready = 1'b1;
        step();
        tests_run++;
        if ({issue_vec(), stat_vec()} !== {1'b1, 5'd3, 3'd2, 32'h30, 32'h40, 1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h want %h", {issue_vec(), stat_vec()}, {1'b1, 5'd3, 3'd2, 32'h30, 32'h40, 1'b1, 4'd0});
        end
        step();
        tests_run++;
        if (bus.issue_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got %b want 0", bus.issue_valid);
        end
    endtask

    task automatic test_flush_and_async_reset();
        bus.issue_ready = 1'b0;
        set_alloc(5'd4, 3'd0, FREE, 32'h40, FREE, 32'h41);
        step();
        for (int i = 1; i < 4; i++) begin
            set_alloc(5'd4, 3'(i), 4'(i), 32'd0, FREE, 32'd0);
            step();
        end
        bus.alloc_valid = 1'b0;
        tests_run++;
        if ({bus.issue_valid, bus.issue_op, stat_vec()} !== {1'b1, 5'd4, 1'b1, 4'd3}) begin
            tests_failed++;
            $display("FAIL flush_setup: got %h want %h", {bus.issue_valid, bus.issue_op, stat_vec()}, {1'b1, 5'd4, 1'b1, 4'd3});
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++;
        if ({bus.issue_valid, stat_vec()} !== {1'b0, 1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL flush_clear: got %h want %h", {bus.issue_valid, stat_vec()}, {1'b0, 1'b1, 4'd0});
        end
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'd2;
        bus.cdb_data  = 32'hDEAD;
        step();
        bus.cdb_valid = 1'b0;
        step();
        tests_run++;
        if ({bus.issue_valid, stat_vec()} !== {1'b0, 1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL flush_stale_cdb: got %h want %h", {bus.issue_valid, stat_vec()}, {1'b0, 1'b1, 4'd0});
        end
        set_alloc(5'd5, 3'd1, FREE, 32'd1, FREE, 32'd2);
        step();
        bus.alloc_valid = 1'b0;
        step();
        tests_run++;
        if (issue_vec() !== {1'b1, 5'd5, 3'd1, 32'd1, 32'd2}) begin
            tests_failed++;
            $display("FAIL async_setup: got %h want %h", issue_vec(), {1'b1, 5'd5, 3'd1, 32'd1, 32'd2});
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({issue_vec(), stat_vec()} !== {73'd0, 1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL async_reset: got %h want %h", {issue_vec(), stat_vec()}, {73'd0, 1'b1, 4'd0});
        end
        #2;
        rst = 1'b0;
        bus.issue_ready = 1'b1;
        step();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_ready_alloc();
        test_cdb_wakeup();
        test_dual_wakeup();
        test_alloc_bypass();
        test_full();
        test_back_to_back();
        test_flush_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
